// File: rtl/mdu_pkg.sv
// -----------------------------------------------------------------------------
// mdu_pkg
// Shared definitions for the M-extension sequencing stage:
//   - funct3 encodings of the eight RV32M operations
//   - INT_MIN, the most negative 32-bit signed value (divide-overflow operand)
//   - state_t, the sequencer FSM state encoding
//   - CNT_W, width of the multicycle-path down-counter
// -----------------------------------------------------------------------------
package mdu_pkg;

   localparam logic [2:0] OP_MUL    = 3'd0;
   localparam logic [2:0] OP_MULH   = 3'd1;
   localparam logic [2:0] OP_MULHSU = 3'd2;
   localparam logic [2:0] OP_MULHU  = 3'd3;
   localparam logic [2:0] OP_DIV    = 3'd4;
   localparam logic [2:0] OP_DIVU   = 3'd5;
   localparam logic [2:0] OP_REM    = 3'd6;
   localparam logic [2:0] OP_REMU   = 3'd7;

   localparam logic [31:0] INT_MIN = 32'h8000_0000;

   localparam int CNT_W = 4;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      WAIT = 2'd1,
      DONE = 2'd2
   } state_t;

endpackage

// File: rtl/mdu_special.sv
// -----------------------------------------------------------------------------
// mdu_special
// Combinational detector for the RISC-V divide corner cases whose result the
// ALU does not define: divide by zero and signed overflow (INT_MIN / -1).
// Ports:
//   op_i          funct3 of the request
//   x_i, y_i      rs1 / rs2 operands
//   special_o     1 when special_val_o must replace the ALU result
//   special_val_o architecturally defined result for the corner case
// -----------------------------------------------------------------------------
module mdu_special
   import mdu_pkg::*;
(
   input  logic [2:0]  op_i,
   input  logic [31:0] x_i,
   input  logic [31:0] y_i,
   output logic        special_o,
   output logic [31:0] special_val_o
);

   logic y_zero;
   logic sgn_ovf;

   assign y_zero  = (y_i == 32'h0000_0000);
   assign sgn_ovf = (x_i == INT_MIN) && (y_i == 32'hFFFF_FFFF);

   always_comb begin
      special_o     = 1'b0;
      special_val_o = 32'h0000_0000;
      case (op_i)
         OP_DIV: begin
            if (y_zero) begin
               special_o     = 1'b1;
               special_val_o = 32'hFFFF_FFFF;
            end else if (sgn_ovf) begin
               special_o     = 1'b1;
               special_val_o = INT_MIN;
            end
         end
         OP_DIVU: begin
            if (y_zero) begin
               special_o     = 1'b1;
               special_val_o = 32'hFFFF_FFFF;
            end
         end
         OP_REM: begin
            if (y_zero) begin
               special_o     = 1'b1;
               special_val_o = x_i;
            end else if (sgn_ovf) begin
               special_o     = 1'b1;
               special_val_o = 32'h0000_0000;
            end
         end
         OP_REMU: begin
            if (y_zero) begin
               special_o     = 1'b1;
               special_val_o = x_i;
            end
         end
         default: begin
            // multiplies are always fully defined by the ALU
         end
      endcase
   end

endmodule

// File: rtl/mdu_seq.sv
// -----------------------------------------------------------------------------
// mdu_seq
// Sequencing stage around the combinational RV32M ALU. Registers the request
// operands so the ALU sees stable inputs for a LATENCY-cycle multicycle path,
// substitutes the defined divide corner-case results, and hands the result
// plus destination tag to writeback.
//
// Build option: define MDU_FASTPATH_EN to let special-case requests complete
// one edge after accept regardless of LATENCY.
//
// Ports:
//   i_clk, i_rst          clock, synchronous active-high reset
//   i_valid/o_ready       request handshake from decode
//   i_op, i_x, i_y, i_rd  request funct3, operands, destination tag
//   i_flush               abort any in-flight op (reset still has priority)
//   o_malu_op/x/y         registered operands driven to the ALU
//   i_malu_result         ALU result, sampled at the capture edge
//   o_valid/i_ready       result handshake to writeback
//   o_result, o_rd        result and destination tag
//   o_busy                high while an op is in WAIT or DONE
// -----------------------------------------------------------------------------
module mdu_seq
   import mdu_pkg::*;
#(
   parameter int LATENCY = 2,
   parameter int TAG_W   = 5
) (
   input  logic             i_clk,
   input  logic             i_rst,
   input  logic             i_valid,
   output logic             o_ready,
   input  logic [2:0]       i_op,
   input  logic [31:0]      i_x,
   input  logic [31:0]      i_y,
   input  logic [TAG_W-1:0] i_rd,
   input  logic             i_flush,
   output logic [2:0]       o_malu_op,
   output logic [31:0]      o_malu_x,
   output logic [31:0]      o_malu_y,
   input  logic [31:0]      i_malu_result,
   output logic             o_valid,
   input  logic             i_ready,
   output logic [31:0]      o_result,
   output logic [TAG_W-1:0] o_rd,
   output logic             o_busy
);

   if (LATENCY < 1 || LATENCY > 15) begin : g_bad_latency
      $error("mdu_seq: LATENCY must be in 1..15");
   end

   localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(LATENCY - 1);

   state_t             state_q, state_d;
   logic [CNT_W-1:0]   cnt_q, cnt_d;
   logic [2:0]         op_q, op_d;
   logic [31:0]        x_q, x_d;
   logic [31:0]        y_q, y_d;
   logic [TAG_W-1:0]   rd_q, rd_d;
   logic               special_q, special_d;
   logic [31:0]        special_val_q, special_val_d;
   logic [31:0]        result_q, result_d;
   logic [TAG_W-1:0]   res_rd_q, res_rd_d;

   logic               accept;
   logic               sp_special;
   logic [31:0]        sp_val;
   logic [CNT_W-1:0]   load_cnt;

   // Special-case detection works on the raw request so the flag is ready
   // to be latched on the accept edge.
   mdu_special u_special (
      .op_i          (i_op),
      .x_i           (i_x),
      .y_i           (i_y),
      .special_o     (sp_special),
      .special_val_o (sp_val)
   );

`ifdef MDU_FASTPATH_EN
   // A special result is already known at accept; it spends a single WAIT
   // edge, matching the timing of a LATENCY=1 operation.
   assign load_cnt = sp_special ? '0 : CNT_LOAD;
`else
   assign load_cnt = CNT_LOAD;
`endif

   // Ready in DONE follows i_ready combinationally so writeback draining a
   // result and decode issuing the next request share one edge.
   assign o_ready = (state_q == IDLE) || ((state_q == DONE) && i_ready);
   assign accept  = i_valid && o_ready && !i_flush;

   always_comb begin
      state_d       = state_q;
      cnt_d         = cnt_q;
      op_d          = op_q;
      x_d           = x_q;
      y_d           = y_q;
      rd_d          = rd_q;
      special_d     = special_q;
      special_val_d = special_val_q;
      result_d      = result_q;
      res_rd_d      = res_rd_q;

      case (state_q)
         IDLE: begin
         end
         WAIT: begin
            if (cnt_q != '0) begin
               cnt_d = cnt_q - 1'b1;
            end else begin
               result_d = special_q ? special_val_q : i_malu_result;
               res_rd_d = rd_q;
               state_d  = DONE;
            end
         end
         DONE: begin
            if (i_ready) begin
               state_d = IDLE;
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase

      // Accept can only occur in IDLE or in DONE while draining, so it
      // overrides the DONE->IDLE move above.
      if (accept) begin
         op_d          = i_op;
         x_d           = i_x;
         y_d           = i_y;
         rd_d          = i_rd;
         special_d     = sp_special;
         special_val_d = sp_val;
         cnt_d         = load_cnt;
         state_d       = WAIT;
      end

      // Flush beats both accept (already gated) and result capture.
      if (i_flush) begin
         state_d  = IDLE;
         cnt_d    = '0;
         result_d = result_q;
         res_rd_d = res_rd_q;
      end
   end

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         state_q       <= IDLE;
         cnt_q         <= '0;
         op_q          <= '0;
         x_q           <= '0;
         y_q           <= '0;
         rd_q          <= '0;
         special_q     <= 1'b0;
         special_val_q <= '0;
         result_q      <= '0;
         res_rd_q      <= '0;
      end else begin
         state_q       <= state_d;
         cnt_q         <= cnt_d;
         op_q          <= op_d;
         x_q           <= x_d;
         y_q           <= y_d;
         rd_q          <= rd_d;
         special_q     <= special_d;
         special_val_q <= special_val_d;
         result_q      <= result_d;
         res_rd_q      <= res_rd_d;
      end
   end

   assign o_malu_op = op_q;
   assign o_malu_x  = x_q;
   assign o_malu_y  = y_q;
   assign o_valid   = (state_q == DONE);
   assign o_busy    = (state_q != IDLE);
   assign o_result  = result_q;
   assign o_rd      = res_rd_q;

endmodule
